// File: rtl/ccsds_iq_axis_packer.sv
// CCSDS I/Q sample packer: packs I/Q pairs into 32-bit beats,
// buffers them in a FIFO and emits AXI-Stream packets.
module ccsds_iq_axis_packer #(
  parameter int SAMPLE_WIDTH = 13,
  parameter int FIFO_DEPTH   = 16,
  parameter int PKT_LEN      = 256,
  parameter bit TAG_EN       = 1'b1
) (
  input  logic                          M_AXIS_ACLK,
  input  logic                          M_AXIS_ARESETN,
  input  logic [SAMPLE_WIDTH-1:0]       i_data_i,
  input  logic [SAMPLE_WIDTH-1:0]       q_data_i,
  input  logic                          valid_i,
  input  logic                          enable_i,
  input  logic                          flush_i,
  output logic                          M_AXIS_TVALID,
  output logic [31:0]                   M_AXIS_TDATA,
  output logic [3:0]                    M_AXIS_TSTRB,
  output logic                          M_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY,
  output logic                          overflow_o,
  output logic [15:0]                   drop_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level_o
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PAD = 14 - SAMPLE_WIDTH;
  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  logic [1:0]      r_rst_sync;
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic            r_tvalid;
  logic [31:0]     r_tdata;
  logic            r_tlast;
  logic [15:0]     r_beat_idx;
  logic            r_flush_pend;
  logic            r_overflow;
  logic [15:0]     r_drop_cnt;

  logic            w_en;
  logic [15:0]     w_i_tag;
  logic [15:0]     w_q_tag;
  logic [15:0]     w_i_sx;
  logic [15:0]     w_q_sx;
  logic [31:0]     w_beat;
  logic [AW:0]     w_fill;
  logic            w_empty;
  logic            w_full;
  logic            w_req;
  logic            w_wr;
  logic            w_drop;
  logic            w_hs;
  logic            w_ld;
  logic            w_flush_ok;
  logic            w_pend;
  logic            w_left_empty;
  logic            w_last;

  // Release is synchronised so the first edges after reset do nothing.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) r_rst_sync <= '0;
    else                 r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_en = r_rst_sync[1];

  assign w_i_tag = 16'({2'b10, i_data_i}) << PAD;
  assign w_q_tag = 16'({2'b01, q_data_i}) << PAD;
  assign w_i_sx  = 16'($signed(i_data_i));
  assign w_q_sx  = 16'($signed(q_data_i));
  assign w_beat  = TAG_EN ? {w_i_tag, w_q_tag}
                          : {w_i_sx, w_q_sx};

  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_req  = valid_i && enable_i && w_en;
  assign w_wr   = w_req && !w_full;
  assign w_drop = w_req && w_full;

  assign w_hs = r_tvalid && M_AXIS_TREADY;
  assign w_ld = w_en && !w_empty &&
                (!r_tvalid || M_AXIS_TREADY);

  // A flush seen this cycle already applies to a beat loaded now.
  assign w_flush_ok   = flush_i && w_en && (!w_empty || r_tvalid);
  assign w_pend       = r_flush_pend || w_flush_ok;
  assign w_left_empty = (w_fill == {{AW{1'b0}}, 1'b1}) && !w_wr;
  assign w_last       = (r_beat_idx == LAST_IDX) ||
                        (w_pend && w_left_empty);

  always_ff @(posedge M_AXIS_ACLK) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= w_beat;
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_tlast      <= 1'b0;
      r_beat_idx   <= '0;
      r_flush_pend <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_ld) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_tvalid   <= 1'b1;
        r_tdata    <= r_mem[r_rd_ptr[AW-1:0]];
        r_tlast    <= w_last;
        r_beat_idx <= w_last ? 16'd0 : r_beat_idx + 16'd1;
      end else if (w_hs) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (w_ld && w_last)  r_flush_pend <= 1'b0;
      else if (w_flush_ok) r_flush_pend <= 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF)
          r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TSTRB  = {4{r_tvalid}};
  assign M_AXIS_TLAST  = r_tlast;
  assign overflow_o    = r_overflow;
  assign drop_count_o  = r_drop_cnt;
  assign fill_level_o  = w_fill;

endmodule

// File: tb/tb_ccsds_iq_axis_packer.sv
// Directed bench for ccsds_iq_axis_packer
// (SAMPLE_WIDTH=13, FIFO_DEPTH=16, PKT_LEN=4, TAG_EN=1).
module tb_ccsds_iq_axis_packer;

  logic        clk;
  logic        rst_n;
  logic [12:0] i_d;
  logic [12:0] q_d;
  logic        valid;
  logic        enable;
  logic        flush;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready;
  logic        ovf;
  logic [15:0] drops;
  logic [4:0]  fill;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] cap_d [64];
  logic        cap_l [64];
  int          cap_n;

  ccsds_iq_axis_packer #(
    .SAMPLE_WIDTH(13),
    .FIFO_DEPTH(16),
    .PKT_LEN(4),
    .TAG_EN(1'b1)
  ) dut (
    .M_AXIS_ACLK(clk),
    .M_AXIS_ARESETN(rst_n),
    .i_data_i(i_d),
    .q_data_i(q_d),
    .valid_i(valid),
    .enable_i(enable),
    .flush_i(flush),
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TDATA(tdata),
    .M_AXIS_TSTRB(tstrb),
    .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready),
    .overflow_o(ovf),
    .drop_count_o(drops),
    .fill_level_o(fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [12:0] si(input int k);
    return 13'(k * 37 + 5);
  endfunction

  function automatic logic [12:0] sq(input int k);
    return 13'(6000 - k * 11);
  endfunction

  function automatic logic [31:0] exp_beat(input int k);
    logic [12:0] a;
    logic [12:0] b;
    a = si(k);
    b = sq(k);
    return {2'b10, a, 1'b0, 2'b01, b, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    i_d = si(k);
    q_d = sq(k);
    valid = 1'b1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
  endtask

  // Drives n samples spaced sp cycles apart and captures every beat.
  task automatic run_seq(input int base, input int n, input int sp,
                         input int flush_at, input int cycles);
    cap_n = 0;
    for (int c = 0; c < cycles; c++) begin
      if ((c % sp == 0) && (c / sp < n)) drive(base + c / sp);
      else valid = 1'b0;
      flush = (c == flush_at);
      if (tvalid && tready) begin
        if (cap_n < 64) begin
          cap_d[cap_n] = tdata;
          cap_l[cap_n] = tlast;
        end
        cap_n++;
      end
      tick();
    end
    valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    enable = 1'b1;
    flush = 1'b0;
    tready = 1'b0;
    i_d = '0;
    q_d = '0;
    #2;
    n_chk++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    n_chk++; if (tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", tdata); end
    n_chk++; if (tstrb !== 4'h0) begin n_fail++; $display("FAIL reset_tstrb: got %h want 0", tstrb); end
    n_chk++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", tlast); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_chk++; if (drops !== 16'h0) begin n_fail++; $display("FAIL reset_drops: got %0d want 0", drops); end
    n_chk++; if (fill !== 5'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_basic();
    tready = 1'b1;
    i_d = 13'h0ABC;
    q_d = 13'h1555;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n_chk++; if (fill !== 5'd1) begin n_fail++; $display("FAIL basic_fill1: got %0d want 1", fill); end
    n_chk++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_early_tvalid: got %b want 0", tvalid); end
    tick();
    n_chk++; if (tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_tvalid: got %b want 1", tvalid); end
    n_chk++; if (tdata !== 32'h9578_6AAA) begin n_fail++; $display("FAIL basic_tdata: got %h want 95786aaa", tdata); end
    n_chk++; if (tstrb !== 4'hF) begin n_fail++; $display("FAIL basic_tstrb: got %h want f", tstrb); end
    n_chk++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL basic_tlast: got %b want 0", tlast); end
    n_chk++; if (fill !== 5'd0) begin n_fail++; $display("FAIL basic_fill0: got %0d want 0", fill); end
    tick();
    n_chk++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", tvalid); end
    n_chk++; if (tstrb !== 4'h0) begin n_fail++; $display("FAIL basic_tstrb_idle: got %h want 0", tstrb); end
  endtask

  task automatic test_pkt_tlast();
    do_reset();
    tready = 1'b1;
    run_seq(0, 8, 1, -1, 16);
    n_chk++; if (cap_n != 8) begin n_fail++; $display("FAIL pkt_count: got %0d want 8", cap_n); end
    for (int b = 0; b < 8 && b < cap_n; b++) begin
      n_chk++; if (cap_d[b] !== exp_beat(b)) begin n_fail++; $display("FAIL pkt_data[%0d]: got %h want %h", b, cap_d[b], exp_beat(b)); end
      n_chk++; if (cap_l[b] !== (b == 3 || b == 7)) begin n_fail++; $display("FAIL pkt_tlast[%0d]: got %b want %b", b, cap_l[b], (b == 3 || b == 7)); end
    end
  endtask

  task automatic test_overflow();
    int nb;
    do_reset();
    tready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(c);
      tick();
    end
    valid = 1'b0;
    n_chk++; if (fill !== 5'd16) begin n_fail++; $display("FAIL ovf_fill: got %0d want 16", fill); end
    n_chk++; if (tvalid !== 1'b1) begin n_fail++; $display("FAIL ovf_stage: got %b want 1", tvalid); end
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    n_chk++; if (drops !== 16'd3) begin n_fail++; $display("FAIL ovf_drops: got %0d want 3", drops); end
    tick();
    tick();
    n_chk++; if (tdata !== exp_beat(0) || tvalid !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %b/%h want 1/%h", tvalid, tdata, exp_beat(0)); end
    tready = 1'b1;
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      if (tvalid) begin
        n_chk++; if (tdata !== exp_beat(nb)) begin n_fail++; $display("FAIL ovf_data[%0d]: got %h want %h", nb, tdata, exp_beat(nb)); end
        n_chk++; if (tlast !== (nb % 4 == 3)) begin n_fail++; $display("FAIL ovf_tlast[%0d]: got %b want %b", nb, tlast, (nb % 4 == 3)); end
        nb++;
      end
      tick();
    end
    n_chk++; if (nb != 17) begin n_fail++; $display("FAIL ovf_beats: got %0d want 17", nb); end
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_reset_mid();
    tready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(100 + c);
      tick();
    end
    valid = 1'b0;
    n_chk++; if (fill !== 5'd5) begin n_fail++; $display("FAIL mid_fill: got %0d want 5", fill); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (tvalid !== 1'b0 || tlast !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid: got %b/%b want 0/0", tvalid, tlast); end
    n_chk++; if (tdata !== 32'h0) begin n_fail++; $display("FAIL mid_tdata: got %h want 0", tdata); end
    n_chk++; if (fill !== 5'd0) begin n_fail++; $display("FAIL mid_fill0: got %0d want 0", fill); end
    n_chk++; if (ovf !== 1'b0 || drops !== 16'd0) begin n_fail++; $display("FAIL mid_ovf: got %b/%0d want 0/0", ovf, drops); end
    tick();
    rst_n = 1'b1;
    drive(200);
    tick();
    valid = 1'b0;
    n_chk++; if (fill !== 5'd0) begin n_fail++; $display("FAIL mid_sync: got %0d want 0", fill); end
    tick();
    tick();
    tready = 1'b1;
    run_seq(300, 4, 1, -1, 12);
    n_chk++; if (cap_n != 4) begin n_fail++; $display("FAIL mid_count: got %0d want 4", cap_n); end
    for (int b = 0; b < 4 && b < cap_n; b++) begin
      n_chk++; if (cap_d[b] !== exp_beat(300 + b)) begin n_fail++; $display("FAIL mid_data[%0d]: got %h want %h", b, cap_d[b], exp_beat(300 + b)); end
      n_chk++; if (cap_l[b] !== (b == 3)) begin n_fail++; $display("FAIL mid_tlast[%0d]: got %b want %b", b, cap_l[b], (b == 3)); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    tready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_seq(400, 4, 3, -1, 18);
    n_chk++; if (cap_n != 4) begin n_fail++; $display("FAIL fl_idle_count: got %0d want 4", cap_n); end
    for (int b = 0; b < 4 && b < cap_n; b++) begin
      n_chk++; if (cap_l[b] !== (b == 3)) begin n_fail++; $display("FAIL fl_idle_tlast[%0d]: got %b want %b", b, cap_l[b], (b == 3)); end
    end
    run_seq(500, 3, 1, 2, 10);
    n_chk++; if (cap_n != 3) begin n_fail++; $display("FAIL fl_count: got %0d want 3", cap_n); end
    for (int b = 0; b < 3 && b < cap_n; b++) begin
      n_chk++; if (cap_d[b] !== exp_beat(500 + b)) begin n_fail++; $display("FAIL fl_data[%0d]: got %h want %h", b, cap_d[b], exp_beat(500 + b)); end
      n_chk++; if (cap_l[b] !== (b == 2)) begin n_fail++; $display("FAIL fl_tlast[%0d]: got %b want %b", b, cap_l[b], (b == 2)); end
    end
    run_seq(600, 4, 1, -1, 10);
    n_chk++; if (cap_n != 4) begin n_fail++; $display("FAIL fl_next_count: got %0d want 4", cap_n); end
    for (int b = 0; b < 4 && b < cap_n; b++) begin
      n_chk++; if (cap_l[b] !== (b == 3)) begin n_fail++; $display("FAIL fl_next_tlast[%0d]: got %b want %b", b, cap_l[b], (b == 3)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] sb [$];
    logic [31:0] want;
    logic [31:0] prev_d;
    logic        prev_l;
    logic        prev_stall;
    int          rx;
    int          tx;
    do_reset();
    rx = 0;
    tx = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    for (int cyc = 0; cyc < 20000 && rx < 1000; cyc++) begin
      if (prev_stall) begin
        n_chk++;
        if (tvalid !== 1'b1 || tdata !== prev_d || tlast !== prev_l) begin
          n_fail++;
          $display("FAIL rnd_hold: got %b/%h/%b want 1/%h/%b", tvalid, tdata, tlast, prev_d, prev_l);
        end
      end
      tready = 1'($urandom_range(0, 1));
      if (tvalid && tready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra: got beat %h want none", tdata);
        end else begin
          want = sb.pop_front();
          if (tdata !== want || tlast !== (rx % 4 == 3)) begin
            n_fail++;
            $display("FAIL rnd_data[%0d]: got %h/%b want %h/%b", rx, tdata, tlast, want, (rx % 4 == 3));
          end
        end
        rx++;
      end
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      prev_l = tlast;
      if (tx < 1000 && fill < 5'd12 && $urandom_range(0, 1) == 1) begin
        drive(tx);
        sb.push_back(exp_beat(tx));
        tx++;
      end else begin
        valid = 1'b0;
      end
      tick();
    end
    valid = 1'b0;
    tready = 1'b1;
    n_chk++; if (rx != 1000) begin n_fail++; $display("FAIL rnd_count: got %0d want 1000", rx); end
    n_chk++; if (drops !== 16'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rnd_drops: got %0d/%b want 0/0", drops, ovf); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pkt_tlast();
    test_overflow();
    test_reset_mid();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
